// File: rtl/sel_shift_pkg.sv
// Shared definitions for the sel_shift_pipe datapath: select modes, shift-amount
// width helper and the bit widths of the stage-1 and stage-2 payload buses.
package sel_shift_pkg;

  localparam logic [1:0] MODE_MIN    = 2'd0;
  localparam logic [1:0] MODE_MAX    = 2'd1;
  localparam logic [1:0] MODE_BYPASS = 2'd2;

  // Width of a shift amount able to address every bit of a dw-bit word.
  function automatic int shw(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  // Stage-1 payload layout, MSB first: d, e, f, lt, eq, shamt, mode.
  function automatic int s1_bits(input int dw, input int sw);
    return 3 * dw + 2 + sw + 2;
  endfunction

  // Stage-2 payload layout, MSB first: g, h, lt, eq, shamt.
  function automatic int s2_bits(input int dw, input int sw);
    return 2 * dw + 2 + sw;
  endfunction

endpackage

// File: rtl/sel_shift_pipe_en_reg.sv
// Parametrised-width register with load enable and asynchronous active-low clear.
module en_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d when enabled, otherwise hold; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sel_shift_pipe.sv
// Three-stage elastic add/compare/select/shift datapath. All stages advance
// together on a single global enable, so a stalled consumer freezes the whole
// pipe and no beat is lost or duplicated.
module sel_shift_pipe
  import sel_shift_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int OUTWIDTH  = 32,
  parameter int SIGNED    = 0
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATAWIDTH-1:0]       a,
  input  logic [DATAWIDTH-1:0]       b,
  input  logic [DATAWIDTH-1:0]       c,
  input  logic [shw(DATAWIDTH)-1:0]  shamt,
  input  logic [1:0]                 mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUTWIDTH-1:0]        x,
  output logic [OUTWIDTH-1:0]        z,
  output logic                       trunc
);

  localparam int DW = DATAWIDTH;
  localparam int OW = OUTWIDTH;
  localparam int SW = shw(DATAWIDTH);
  localparam int S1 = s1_bits(DATAWIDTH, SW);
  localparam int S2 = s2_bits(DATAWIDTH, SW);
  localparam int S3 = 2 * OUTWIDTH + 1;

  logic          adv_s;
  logic [DW-1:0] d_s, e_s, f_s;
  logic          lt_s, eq_s;
  logic [DW-1:0] g_s, h_s;
  logic [DW-1:0] xs_s, zs_s;
  logic          trunc_s;

  logic          v1_r, v2_r;
  logic [S1-1:0] p1_r;
  logic [S2-1:0] p2_r;
  logic [S3-1:0] p3_r;

  logic [DW-1:0] d1_r, e1_r, f1_r;
  logic          lt1_r, eq1_r;
  logic [SW-1:0] sh1_r;
  logic [1:0]    mode1_r;
  logic [DW-1:0] g2_r, h2_r;
  logic          lt2_r, eq2_r;
  logic [SW-1:0] sh2_r;

  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  assign {d1_r, e1_r, f1_r, lt1_r, eq1_r, sh1_r, mode1_r} = p1_r;
  assign {g2_r, h2_r, lt2_r, eq2_r, sh2_r}                = p2_r;
  assign {x, z, trunc}                                    = p3_r;

  // Stage-1 arithmetic: wrap-around sums/difference and the sum comparison.
  always_comb begin
    d_s = a + b;
    e_s = a + c;
    f_s = a - b;
    if (SIGNED != 0) begin
      lt_s = $signed(d_s) < $signed(e_s);
    end else begin
      lt_s = d_s < e_s;
    end
    eq_s = (d_s == e_s);
  end

  // Stage-2 select: reserved mode falls through to MIN.
  always_comb begin
    case (mode1_r)
      MODE_MAX:    g_s = lt1_r ? e1_r : d1_r;
      MODE_BYPASS: g_s = d1_r;
      default:     g_s = lt1_r ? d1_r : e1_r;
    endcase
    if (mode1_r == MODE_BYPASS || eq1_r) begin
      h_s = f1_r;
    end else begin
      h_s = g_s;
    end
  end

  // Stage-3 shift: full-width shifts, overflow past DATAWIDTH is simply lost.
  always_comb begin
    xs_s = h2_r << (lt2_r ? sh2_r : {SW{1'b0}});
    zs_s = g2_r << (eq2_r ? sh2_r : {SW{1'b0}});
  end

  if (OW < DW) begin : g_trunc
    assign trunc_s = (|xs_s[DW-1:OW]) || (|zs_s[DW-1:OW]);
  end else begin : g_notrunc
    assign trunc_s = 1'b0;
  end

  en_reg #(.W(1))  u_v1 (.clk(Clk), .rst_n(Rst), .en(adv_s), .d(in_valid), .q(v1_r));
  en_reg #(.W(S1)) u_p1 (.clk(Clk), .rst_n(Rst), .en(adv_s),
                         .d({d_s, e_s, f_s, lt_s, eq_s, shamt, mode}), .q(p1_r));
  en_reg #(.W(1))  u_v2 (.clk(Clk), .rst_n(Rst), .en(adv_s), .d(v1_r), .q(v2_r));
  en_reg #(.W(S2)) u_p2 (.clk(Clk), .rst_n(Rst), .en(adv_s),
                         .d({g_s, h_s, lt1_r, eq1_r, sh1_r}), .q(p2_r));
  en_reg #(.W(1))  u_v3 (.clk(Clk), .rst_n(Rst), .en(adv_s), .d(v2_r), .q(out_valid));
  en_reg #(.W(S3)) u_p3 (.clk(Clk), .rst_n(Rst), .en(adv_s),
                         .d({xs_s[OW-1:0], zs_s[OW-1:0], trunc_s}), .q(p3_r));

endmodule
